recon_luma4x4: RTL and testbench

Reconstruction stage for 4x4 intra luma blocks: the inverse of the residual generator. It accepts one block of prediction samples and one block of decoded residuals, and adds them row by row with saturation to 0..255. It presents the reconstructed block together with its bottom row and right column, which the intra predictor uses as neighbours for the next block. It sits between the inverse-transform output and the intra-prediction neighbour store.

---
 rtl/recon_luma4x4_if.sv | 40 ++++
 rtl/recon_luma4x4.sv | 132 +++++++++++++
 tb/tb_recon_luma4x4.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/recon_luma4x4_if.sv
`default_nettype none
// ============================================================================
// Module      : recon_luma4x4_if
// Description : Block handshake bundle for the 4x4 luma reconstruction stage.
//               Carries the pred/res input block, the reconstructed output
//               block and its intra-prediction neighbour views.
// Revision    : 1.0 - initial release
// ============================================================================
interface recon_luma4x4_if #(
  parameter int RES_W = 9
) ();

  // Input side: prediction + residual block, raster order (index = 4*row+col)
  logic                        in_valid;
  logic                        in_ready;
  logic [15:0][7:0]            pred;
  logic [15:0][RES_W-1:0]      res;

  // Output side: reconstructed block and its neighbour views
  logic                        out_valid;
  logic                        out_ready;
  logic [15:0][7:0]            recon;
  logic [3:0][7:0]             bottom_row;
  logic [3:0][7:0]             right_col;
  logic [3:0]                  blk_idx;

  // Reconstruction stage side
  modport slave (
    input  in_valid, pred, res, out_ready,
    output in_ready, out_valid, recon, bottom_row, right_col, blk_idx
  );

  // Producer/consumer side
  modport master (
    output in_valid, pred, res, out_ready,
    input  in_ready, out_valid, recon, bottom_row, right_col, blk_idx
  );

endinterface
`default_nettype wire

// File: rtl/recon_luma4x4.sv
`default_nettype none
// ============================================================================
// Module      : recon_luma4x4
// Description : 4x4 intra luma reconstruction. Latches one block of
//               prediction samples and signed residuals, adds them one row
//               per cycle with saturation to 0..255, then presents the block
//               plus its bottom row / right column as prediction neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
module recon_luma4x4 #(
  parameter int RES_W = 9
) (
  input  logic          clk,
  input  logic          reset,    // asynchronous, active-low
  input  logic          enable,   // global advance; 0 freezes all state
  recon_luma4x4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturation bound expressed at the full sum width so compares stay signed
  localparam logic signed [RES_W:0] PIX_MAX = (RES_W+1)'(255);

  state_t                      state;
  logic [1:0]                  row;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [3:0]                  blk_q;

  // Row-major storage: [row][col][sample], same bit layout as the raster bus
  logic [3:0][3:0][7:0]        pred_q;
  logic [3:0][3:0][RES_W-1:0]  res_q;
  logic [3:0][3:0][7:0]        recon_q;

  // Saturated sums for the row currently addressed by the row counter
  logic [3:0][7:0]             row_sum;

  // Unsigned pred + signed residual, clipped to the 8-bit pixel range.
  // RES_W+1 bits is enough for -2^(RES_W-1) .. 255 + 2^(RES_W-1)-1.
  function automatic logic [7:0] clip_add(input logic [7:0] p,
                                          input logic [RES_W-1:0] r);
    logic signed [RES_W:0] sum;
    sum = $signed({{(RES_W-7){1'b0}}, p}) + $signed({r[RES_W-1], r});
    if (sum[RES_W]) begin
      clip_add = 8'd0;
    end else if (sum > PIX_MAX) begin
      clip_add = 8'hff;
    end else begin
      clip_add = sum[7:0];
    end
  endfunction

  // Four column adders shared across rows; the row counter selects the operands
  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign row_sum[c] = clip_add(pred_q[row][c], res_q[row][c]);
    end
  endgenerate

  // Neighbour views are pure wiring off the recon register
  assign bus.bottom_row = recon_q[3];
  generate
    for (genvar r = 0; r < 4; r++) begin : g_right
      assign bus.right_col[r] = recon_q[r][3];
    end
  endgenerate

  assign bus.recon     = recon_q;
  assign bus.blk_idx   = blk_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  // Block FSM: accept, reconstruct one row per enabled cycle, hold until taken.
  // Handshake flags are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      row         <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      blk_q       <= 4'd0;
      pred_q      <= '0;
      res_q       <= '0;
      recon_q     <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Inputs are captured here so the source may change them at once
            pred_q     <= bus.pred;
            res_q      <= bus.res;
            row        <= 2'd0;
            in_ready_q <= 1'b0;
            state      <= ROW;
          end
        end

        ROW: begin
          // Rows not yet reached keep the previous block's samples
          recon_q[row] <= row_sum;
          row          <= row + 2'd1;
          if (row == 2'd3) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            blk_q       <= blk_q + 4'd1;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean idle
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_recon_luma4x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_recon_luma4x4
// Description : Self-checking bench for recon_luma4x4. A queue-based model
//               predicts every delivered block; a compare process checks each
//               cycle out_valid is high, and directed literals pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recon_luma4x4;

  localparam int RES_W = 9;

  typedef logic [15:0][7:0]       blk_t;
  typedef logic [15:0][RES_W-1:0] rblk_t;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b1;

  recon_luma4x4_if #(.RES_W(RES_W)) bus ();

  recon_luma4x4 #(.RES_W(RES_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  blk_t       exp_q[$];
  logic [3:0] exp_blk = 4'd0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference: integer add then clamp to the pixel range
  function automatic blk_t model(input blk_t p, input rblk_t r);
    blk_t m;
    for (int i = 0; i < 16; i++) begin
      int s;
      s = int'(p[i]) + int'($signed(r[i]));
      if (s < 0)   s = 0;
      if (s > 255) s = 255;
      m[i] = 8'(s);
    end
    return m;
  endfunction

  // Model bookkeeping: push on accept, pop and count on delivery, flush on reset
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_blk = 4'd0;
    end else if (enable) begin
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        exp_blk = exp_blk + 4'd1;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.pred, bus.res));
    end
  end

  // Compare every presented block against the model
  always @(negedge clk) begin
    blk_t e;
    if (reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_block: out_valid=1 with no block expected");
      end else begin
        e = exp_q[0];
        check("recon", bus.recon, e);
        check("bottom_row", bus.bottom_row, {e[15], e[14], e[13], e[12]});
        check("right_col", bus.right_col, {e[15], e[11], e[7], e[3]});
        check("blk_idx", bus.blk_idx, exp_blk);
        check("in_ready_in_done", bus.in_ready, 1'b0);
      end
    end
  end

  task automatic put_block(input blk_t p, input rblk_t r, output int tries);
    bus.pred = p;
    bus.res = r;
    bus.in_valid = 1'b1;
    tries = 0;
    while (!bus.in_ready && tries < 20) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!bus.in_ready) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", tries);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.pred[i] = 8'($urandom);
      bus.res[i]  = RES_W'($urandom);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) begin
      n_total++;
      $display("FAIL done_timeout: out_valid=0 after %0d cycles, expected 1", lat);
    end
  endtask

  task automatic finish_block(input int bp);
    bus.out_ready = 1'b0;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_in_ready", bus.in_ready, 1'b1);
    check("release_out_valid", bus.out_valid, 1'b0);
  endtask

  task automatic rand_block(output blk_t p, output rblk_t r);
    for (int i = 0; i < 16; i++) begin
      p[i] = 8'($urandom);
      r[i] = RES_W'($urandom);
    end
  endtask

  initial begin
    blk_t  p, lit;
    rblk_t r;
    int    tries, lat;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.pred      = '0;
    bus.res       = '0;

    // Reset state
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_recon", bus.recon, '0);
    check("rst_blk_idx", bus.blk_idx, 4'd0);

    // Basic add; accepted on the very first edge after reset release
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      p[i] = 8'd100;
      r[i] = RES_W'(i - 8);
      lit[i] = 8'(92 + i);
    end
    put_block(p, r, tries);
    check("first_accept_tries", tries, 0);
    wait_done(lat);
    check("basic_latency", lat, 4);
    check("basic_recon_lit", bus.recon, lit);
    check("basic_blk_idx_lit", bus.blk_idx, 4'd0);
    finish_block(0);

    // Saturation high
    for (int i = 0; i < 16; i++) begin p[i] = 8'd250; r[i] = RES_W'(20); end
    put_block(p, r, tries);
    wait_done(lat);
    lit = '1;
    check("sat_high_lit", bus.recon, lit);
    finish_block(1);

    // Saturation low: most negative residual
    for (int i = 0; i < 16; i++) begin p[i] = 8'd5; r[i] = RES_W'(-256); end
    put_block(p, r, tries);
    wait_done(lat);
    check("sat_low_lit", bus.recon, '0);
    finish_block(1);

    // Mixed: pred 0 + 255, pred 200 + 100
    for (int i = 0; i < 16; i++) begin
      p[i] = (i % 2 == 0) ? 8'd0 : 8'd200;
      r[i] = (i % 2 == 0) ? RES_W'(255) : RES_W'(100);
    end
    put_block(p, r, tries);
    wait_done(lat);
    lit = '1;
    check("sat_mixed_lit", bus.recon, lit);
    finish_block(0);

    // Neighbours
    for (int i = 0; i < 16; i++) begin p[i] = 8'(16 * i); r[i] = '0; end
    put_block(p, r, tries);
    wait_done(lat);
    check("nbr_bottom_lit", bus.bottom_row, {8'd240, 8'd224, 8'd208, 8'd192});
    check("nbr_right_lit", bus.right_col, {8'd240, 8'd176, 8'd112, 8'd48});
    finish_block(0);

    // Enable gating: 5 frozen edges after row 1 is written
    rand_block(p, r);
    put_block(p, r, tries);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) enable = 1'b0;
      if (lat == 7) enable = 1'b1;
    end
    enable = 1'b1;
    check("enable_latency", lat, 9);
    finish_block(0);

    // Backpressure and index wrap: 17 blocks, 3 stalled DONE cycles each
    for (int b = 0; b < 17; b++) begin
      rand_block(p, r);
      put_block(p, r, tries);
      wait_done(lat);
      check("bp_latency", lat, 4);
      finish_block(3);
    end
    check("wrap_blk_idx_lit", bus.blk_idx, 4'd7);

    // Mid-block reset during row 2
    rand_block(p, r);
    put_block(p, r, tries);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_recon", bus.recon, '0);
    check("midrst_blk_idx", bus.blk_idx, 4'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      p[i] = 8'd100;
      r[i] = RES_W'(i - 8);
      lit[i] = 8'(92 + i);
    end
    put_block(p, r, tries);
    wait_done(lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_recon_lit", bus.recon, lit);
    check("post_rst_blk_idx_lit", bus.blk_idx, 4'd0);
    finish_block(0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
